// File: rtl/uart_fifo_bridge.sv
// ----------------------------------------------------------------------------
// uart_fifo_bridge
//
// Purpose: decouples a CSR-style register interface from a UART datapath
// with two independent byte FIFOs.
//   TX path: CSR writes (tx_wr_i/tx_data_i) -> TX FIFO -> AXI-Stream master
//            (m_axis_*) toward the UART transmitter.
//   RX path: AXI-Stream slave (s_axis_*) from the UART receiver -> RX FIFO
//            -> CSR reads (rx_rd_i/rx_data_o).
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   tx_wr_i, tx_data_i   TX byte write strobe and byte
//   tx_full_o            TX FIFO holds DEPTH entries
//   tx_level_o           TX FIFO occupancy
//   rx_rd_i              RX byte read strobe (pops the head)
//   rx_data_o            RX FIFO head byte
//   rx_not_empty_o       RX FIFO holds at least one byte
//   rx_level_o           RX FIFO occupancy
//   m_axis_tdata_o/tvalid_o/tready_i   TX stream to the UART transmitter
//   s_axis_tdata_i/tvalid_i/tready_o   RX stream from the UART receiver
//
// Each FIFO is a DEPTH-entry array with read/write pointers that wrap
// modulo DEPTH (DEPTH is a power of two, so the wrap is the natural
// overflow of the pointer) and an LW-bit occupancy count. Status outputs
// are derived from the registered counts only, so there is never a
// combinational path from a push input to an output.
// ----------------------------------------------------------------------------
module uart_fifo_bridge #(
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          tx_wr_i,
    input  logic [7:0]    tx_data_i,
    output logic          tx_full_o,
    output logic [LW-1:0] tx_level_o,

    input  logic          rx_rd_i,
    output logic [7:0]    rx_data_o,
    output logic          rx_not_empty_o,
    output logic [LW-1:0] rx_level_o,

    output logic [7:0]    m_axis_tdata_o,
    output logic          m_axis_tvalid_o,
    input  logic          m_axis_tready_i,

    input  logic [7:0]    s_axis_tdata_i,
    input  logic          s_axis_tvalid_i,
    output logic          s_axis_tready_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    tx_mem [DEPTH];
    logic [PW-1:0] tx_rd_ptr_reg, tx_wr_ptr_reg;
    logic [LW-1:0] tx_count_reg,  tx_count_next;
    logic          tx_push, tx_pop;

    assign tx_full_o       = (tx_count_reg == LW'(DEPTH));
    assign tx_level_o      = tx_count_reg;
    assign m_axis_tvalid_o = (tx_count_reg != '0);
    assign m_axis_tdata_o  = tx_mem[tx_rd_ptr_reg];

    // A write while full is dropped even if a pop frees a slot in the same
    // cycle: fullness is judged on the registered count only.
    assign tx_push = tx_wr_i && !tx_full_o && !rst_i;
    assign tx_pop  = m_axis_tvalid_o && m_axis_tready_i;

    always_comb begin
        tx_count_next = tx_count_reg;
        case ({tx_push, tx_pop})
            2'b10:   tx_count_next = tx_count_reg + LW'(1);
            2'b01:   tx_count_next = tx_count_reg - LW'(1);
            default: tx_count_next = tx_count_reg;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_rd_ptr_reg <= '0;
            tx_wr_ptr_reg <= '0;
            tx_count_reg  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + PW'(1);
            if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + PW'(1);
            tx_count_reg <= tx_count_next;
        end
    end

    // Storage is never reset; stale bytes are unreachable once count is 0.
    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wr_ptr_reg] <= tx_data_i;
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    rx_mem [DEPTH];
    logic [PW-1:0] rx_rd_ptr_reg, rx_wr_ptr_reg;
    logic [LW-1:0] rx_count_reg,  rx_count_next;
    logic          rx_push, rx_pop;

    assign s_axis_tready_o = (rx_count_reg != LW'(DEPTH));
    assign rx_not_empty_o  = (rx_count_reg != '0);
    assign rx_level_o      = rx_count_reg;
    assign rx_data_o       = rx_mem[rx_rd_ptr_reg];

    // The receiver holds its byte while tready is low, so nothing is lost.
    assign rx_push = s_axis_tvalid_i && s_axis_tready_o && !rst_i;
    assign rx_pop  = rx_rd_i && rx_not_empty_o;

    always_comb begin
        rx_count_next = rx_count_reg;
        case ({rx_push, rx_pop})
            2'b10:   rx_count_next = rx_count_reg + LW'(1);
            2'b01:   rx_count_next = rx_count_reg - LW'(1);
            default: rx_count_next = rx_count_reg;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_rd_ptr_reg <= '0;
            rx_wr_ptr_reg <= '0;
            rx_count_reg  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + PW'(1);
            if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + PW'(1);
            rx_count_reg <= rx_count_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rx_push) rx_mem[rx_wr_ptr_reg] <= s_axis_tdata_i;
    end

endmodule
